// File: rtl/jtdsp16_pio_host.sv
// DSP16 parallel I/O host-side controller: host command FIFO drained by DSP reads,
// reply latch filled by DSP writes, psel=1 status/control register and DSP irq.
module jtdsp16_pio_host #(
   parameter int AW = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        host_wr,
   input  logic [15:0] host_din,
   output logic        host_full,
   input  logic        host_rd,
   output logic [15:0] host_dout,
   output logic        host_rdy,
   input  logic        pods_n,
   input  logic        pids_n,
   input  logic        psel,
   input  logic [15:0] pbus_out,
   output logic [15:0] pbus_in,
   output logic        irq,
   output logic        ovf,
   output logic        lost
);

   localparam int          DEPTH     = 1 << AW;
   localparam logic [AW:0] CNT_FULL  = DEPTH[AW:0];
   localparam logic [AW:0] CNT_ONE   = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   logic [15:0]   mem [DEPTH];

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   hostDout_q, hostDout_d;
   logic          hostRdy_q, hostRdy_d;
   logic          ovf_q, ovf_d;
   logic          lost_q, lost_d;
   logic          irqEn_q, irqEn_d;
   logic          irq_q, irq_d;
   logic          lastPodsN_q;
   logic          lastPidsN_q;

   logic          wrEnd, rdEnd;
   logic          full, empty;
   logic          ctrlWr, flush, clearFlags;
   logic          push, pop, replyWr;
   logic          ovfEvent, lostEvent;
   logic [3:0]    countExt;

   // Transfers commit when the strobe is first seen high again, so pbus_in is
   // stable for the whole low phase while the DSP samples it.
   always_comb begin
      wrEnd      = pods_n & ~lastPodsN_q;
      rdEnd      = pids_n & ~lastPidsN_q;
      full       = (count_q == CNT_FULL);
      empty      = (count_q == '0);
      ctrlWr     = cen & wrEnd & psel;
      flush      = ctrlWr & pbus_out[1];
      clearFlags = ctrlWr & pbus_out[0];
      replyWr    = cen & wrEnd & ~psel;
      push       = cen & host_wr & ~full & ~flush;
      pop        = cen & rdEnd & ~psel & ~empty & ~flush;
      ovfEvent   = cen & host_wr & full & ~flush;
      lostEvent  = replyWr & hostRdy_q & ~host_rd;
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) wrPtr_d = wrPtr_q + PTR_ONE;
         if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
         if (push && !pop)
            count_d = count_q + CNT_ONE;
         else if (pop && !push)
            count_d = count_q - CNT_ONE;
      end
   end

   // A host read colliding with a reply write loses to the write.
   always_comb begin
      hostDout_d = hostDout_q;
      hostRdy_d  = hostRdy_q;
      irqEn_d    = irqEn_q;
      if (replyWr) begin
         hostDout_d = pbus_out;
         hostRdy_d  = 1'b1;
      end else if (cen && host_rd) begin
         hostRdy_d  = 1'b0;
      end
      if (ctrlWr) irqEn_d = pbus_out[2];
      ovf_d  = (ovf_q  & ~clearFlags) | ovfEvent;
      lost_d = (lost_q & ~clearFlags) | lostEvent;
      irq_d  = irqEn_q & (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         hostDout_q  <= '0;
         hostRdy_q   <= 1'b0;
         ovf_q       <= 1'b0;
         lost_q      <= 1'b0;
         irqEn_q     <= 1'b0;
         irq_q       <= 1'b0;
         lastPodsN_q <= 1'b1;
         lastPidsN_q <= 1'b1;
      end else if (cen) begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         hostDout_q  <= hostDout_d;
         hostRdy_q   <= hostRdy_d;
         ovf_q       <= ovf_d;
         lost_q      <= lost_d;
         irqEn_q     <= irqEn_d;
         irq_q       <= irq_d;
         lastPodsN_q <= pods_n;
         lastPidsN_q <= pids_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr_q] <= host_din;
   end

   always_comb begin
      countExt       = '0;
      countExt[AW:0] = count_q;
      if (psel)
         pbus_in = {8'h00, ovf_q, lost_q, hostRdy_q, full, countExt};
      else if (empty)
         pbus_in = 16'h0000;
      else
         pbus_in = mem[rdPtr_q];
   end

   assign host_full = full;
   assign host_dout = hostDout_q;
   assign host_rdy  = hostRdy_q;
   assign irq       = irq_q;
   assign ovf       = ovf_q;
   assign lost      = lost_q;

endmodule

// File: doc/jtdsp16_pio_host.md
# jtdsp16_pio_host

Peripheral-side controller for the DSP16 parallel I/O port. It sits between the host CPU and the DSP's `pbus`/`pods_n`/`pids_n`/`psel` pins and turns strobed port cycles into buffered transfers in both directions:
- Host-to-DSP: a command FIFO drained by DSP reads.
- DSP-to-host: a single reply latch filled by DSP writes.
- A `psel=1` status/control register.
- An interrupt request to the DSP that tells it commands are pending.

## Interface

Clocking and reset: one clock; reset is asynchronous and active-low. The ports are named `clk` and `rst_n`.

Parameters:
- `AW`, default 2: FIFO address width. Depth is 2^AW. Legal range is 1..3.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `cen`  in  1  clock enable, same phase as the DSP `ph1`. All state changes only on `clk` edges with `cen=1`.
- `host_wr`  in  1  host push request
- `host_din`  in  16  host push data
- `host_full`  out  1  FIFO full
- `host_rd`  in  1  host acknowledge of the reply latch
- `host_dout`  out  16  reply latch contents
- `host_rdy`  out  1  reply latch holds an unread word
- `pods_n`  in  1  DSP output data strobe, active low
- `pids_n`  in  1  DSP input data strobe, active low
- `psel`  in  1  DSP peripheral select
- `pbus_out`  in  16  data driven by the DSP
- `pbus_in`  out  16  data returned to the DSP
- `irq`  out  1  interrupt request to the DSP
- `ovf`  out  1  sticky: host push rejected because the FIFO was full
- `lost`  out  1  sticky: reply overwritten before the host read it

## Operation

**FIFO**
- Holds 2^AW × 16-bit words, with read/write pointers and a count register of AW+1 bits.
- `host_full` = (count == 2^AW).
- Pointers wrap modulo 2^AW.

**Strobe edge detection**
- `last_pods_n` and `last_pids_n` are registered on `cen`.
- `wr_end` = `pods_n & ~last_pods_n`.
- `rd_end` = `pids_n & ~last_pids_n`.
- Transfers commit at the end of a strobe, so `pbus_in` stays stable for the whole strobe. The DSP samples in the last low cycle.

**Host push**
- On `cen & host_wr & ~host_full`: write `host_din` at the write pointer, increment the pointer and count.
- `host_wr` while full: data is dropped and `ovf` is set.

**DSP read, `psel=0`**
- `pbus_in` = FIFO head. If the FIFO is empty, `pbus_in` = 16'h0000.
- On `rd_end` with `psel=0` and the FIFO not empty: pop.
- On `rd_end` with `psel=0` and the FIFO empty: no state change.

**DSP read, `psel=1`**
- `pbus_in` = {8'd0, `ovf`, `lost`, `host_rdy`, `host_full`, count zero-extended to 4 bits}.

**DSP write, `psel=0`, on `wr_end`**
- `host_dout` <= `pbus_out` and `host_rdy` <= 1.
- If `host_rdy` was already 1, set `lost`.

**DSP write, `psel=1`, on `wr_end`** (control register)
- bit0 = 1: clear `ovf` and `lost`.
- bit1 = 1: flush the FIFO (pointers and count to 0).
- bit2: `irq_en` <= `pbus_out[2]`.

**Host read**
- On `cen & host_rd`: `host_rdy` <= 0. `host_dout` holds its value.

**Interrupt**
- `irq` is a register updated on `cen`: `irq` <= `irq_en` & (count_next != 0).

**Simultaneous events**
- Push and pop in the same `cen`: count is unchanged and both pointers advance.
- Push while full with a pop in the same cycle: the push is rejected (fullness is evaluated before the pop) and `ovf` is set.
- Flush with a push in the same cycle: flush wins; the push is discarded without setting `ovf`.
- Flush with a pop in the same cycle: flush wins.
- `host_rd` and a DSP `psel=0` write in the same cycle: the write wins, so `host_rdy` = 1 and `lost` is unchanged.
- Control clear with a new `ovf`/`lost` event in the same cycle: the event wins, so the flag is set.

**Reset**
- All registers go to 0: pointers, count, `host_dout`, `host_rdy`, `ovf`, `lost`, `irq_en`, `irq`.
- `last_pods_n` and `last_pids_n` go to 1, so no false edge is seen after reset.
- Reset asserted mid-strobe aborts the transfer. The strobe's later rising edge is still seen and commits against the reset state: a pop on an empty FIFO is ignored.

## Timing

- Host push: `host_full`, count and `pbus_in` update on the `clk` edge with `cen`. `irq` follows on the same edge, via count_next.
- `pbus_in` is combinational from the head, count, `psel` and the status flags. There are no wait states.
- Pop and reply capture commit on the `cen` cycle in which the strobe is seen high for the first time. That is one `cen` after the DSP releases the strobe. Flags are visible on the next `clk`.
- `irq` deasserts on the same `cen` cycle as the pop that empties the FIFO. This gives the DSP's `irq` posedge detector a clean edge for the next command.
- With `cen` low, all outputs hold.

## Test plan

- **Reset:** assert `rst_n=0` mid-operation → all outputs 0, `pbus_in`=0000; the first `pids_n` rise after release causes no pop.
- **Fill and drain:**
  - Push 1111, 2222, 3333, 4444 (AW=2) → `host_full`=1; a fifth push of 5555 sets `ovf`.
  - With `irq_en` enabled, four DSP `psel=0` reads return 1111..4444 in order; `irq` drops after the fourth pop.
  - A fifth read returns 0000.
- **Status and control:** `psel=1` read after three pushes → 0003 (plus 0080 if `ovf` is set). A control write of 0003 → count 0, `ovf`=0; the next status read returns 0000.
- **Reply path:**
  - DSP writes ABCD with `psel=0` → `host_rdy`=1, `host_dout`=ABCD.
  - A second write of 1234 before `host_rd` → `lost`=1, `host_dout`=1234.
  - `host_rd` → `host_rdy`=0.
- **Collisions:**
  - Push and pop in the same `cen` with count=2 → count stays 2.
  - Push while full with a pop → `ovf`=1 and count=3.
  - Flush with a push → count 0, `ovf` unchanged.
- **Pointer wrap:** 10 push/pop pairs with AW=2 → data order is preserved across the wrap, and count never exceeds 4.
